wb_b3_ram_responder: RTL and testbench

WB_B3_RAM_RESPONDER -- requirements
Module: wb_b3_ram_responder

---
 rtl/wb_b3_pkg.sv | 44 ++++
 rtl/wb_b3_adr_inc.sv | 31 +++
 rtl/wb_b3_ram_responder.sv | 129 ++++++++++++
 tb/tb_wb_b3_ram_responder.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_b3_pkg.sv
// Shared Wishbone B3 registered-feedback encodings and responder FSM states.
// Reused by any burst-capable slave in this codebase.
package wb_b3_pkg;

   typedef enum logic [2:0] {
      CTI_CLASSIC = 3'b000,
      CTI_CONST   = 3'b001,
      CTI_INCR    = 3'b010,
      CTI_EOB     = 3'b111
   } cti_e;

   typedef enum logic [1:0] {
      BTE_LINEAR = 2'b00,
      BTE_WRAP4  = 2'b01,
      BTE_WRAP8  = 2'b10,
      BTE_WRAP16 = 2'b11
   } bte_e;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'b00,
      ST_WAIT        = 2'b01,
      ST_ACK_CLASSIC = 2'b10,
      ST_BURST       = 2'b11
   } state_e;

   localparam int WCNT_W = 3;

   // Reserved cti codes are served as single classic transfers.
   function automatic logic is_burst_cti(input logic [2:0] cti);
      return (cti == CTI_CONST) || (cti == CTI_INCR);
   endfunction

   function automatic logic [3:0] wrap_mask(input logic [1:0] bte);
      logic [3:0] m;
      case (bte)
         BTE_WRAP4:  m = 4'h3;
         BTE_WRAP8:  m = 4'h7;
         BTE_WRAP16: m = 4'hF;
         default:    m = 4'h0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/wb_b3_adr_inc.sv
// Next word address for a Wishbone B3 burst beat: linear, wrapping, or held.
// Purely combinational so any burst responder can share it.
module wb_b3_adr_inc
   import wb_b3_pkg::*;
#(
   parameter int ADR_WIDTH = 10
) (
   input  logic [ADR_WIDTH-1:0] adr_i,
   input  logic [2:0]           cti_i,
   input  logic [1:0]           bte_i,
   output logic [ADR_WIDTH-1:0] adr_o
);

   logic [ADR_WIDTH-1:0] inc;
   logic [ADR_WIDTH-1:0] mask;

   always_comb begin
      inc   = adr_i + ADR_WIDTH'(1);
      mask  = ADR_WIDTH'(wrap_mask(bte_i));
      adr_o = adr_i;
      if (cti_i == CTI_INCR) begin
         if (bte_i == BTE_LINEAR) begin
            adr_o = inc;
         end else begin
            // Wrapping bursts count inside the aligned block only.
            adr_o = (adr_i & ~mask) | (inc & mask);
         end
      end
   end

endmodule

// File: rtl/wb_b3_ram_responder.sv
// Wishbone B3 single-port RAM slave with classic and registered-feedback
// burst support plus a configurable number of initial wait states.
module wb_b3_ram_responder
   import wb_b3_pkg::*;
#(
   parameter int ADR_WIDTH   = 10,
   parameter int WAIT_STATES = 0
) (
   input  logic        wb_clk,
   input  logic        wb_rst,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [2:0]  wb_cti_i,
   input  logic [1:0]  wb_bte_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o
);

   localparam int                DEPTH     = 2 ** ADR_WIDTH;
   localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(WAIT_STATES);

   state_e               state_q, state_d;
   logic [ADR_WIDTH-1:0] adr_q, adr_d;
   logic [ADR_WIDTH-1:0] adr_next;
   logic [ADR_WIDTH-1:0] adr_req;
   logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
   logic                 req;
   logic                 wr_en;
   logic [31:0]          mem_q [DEPTH];
   logic                 unused_adr_bits;

   assign req     = wb_cyc_i & wb_stb_i;
   assign adr_req = wb_adr_i[ADR_WIDTH+1:2];
   // Upper address bits alias; byte offset is covered by wb_sel_i.
   assign unused_adr_bits = ^{wb_adr_i[31:ADR_WIDTH+2], wb_adr_i[1:0]};

   wb_b3_adr_inc #(
      .ADR_WIDTH(ADR_WIDTH)
   ) u_adr_inc (
      .adr_i(adr_q),
      .cti_i(wb_cti_i),
      .bte_i(wb_bte_i),
      .adr_o(adr_next)
   );

   function automatic state_e service_state(input logic [2:0] cti);
      return is_burst_cti(cti) ? ST_BURST : ST_ACK_CLASSIC;
   endfunction

   always_comb begin
      state_d  = state_q;
      adr_d    = adr_q;
      wcnt_d   = wcnt_q;
      wb_ack_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               adr_d  = adr_req;
               wcnt_d = WAIT_INIT;
               if (WAIT_STATES > 0) begin
                  state_d = ST_WAIT;
               end else begin
                  state_d = service_state(wb_cti_i);
               end
            end
         end
         ST_WAIT: begin
            if (!wb_cyc_i) begin
               state_d = ST_IDLE;
            end else begin
               wcnt_d = wcnt_q - WCNT_W'(1);
               // Leave on the cycle the counter reaches zero.
               if (wcnt_q <= WCNT_W'(1)) begin
                  state_d = service_state(wb_cti_i);
               end
            end
         end
         ST_ACK_CLASSIC: begin
            wb_ack_o = req;
            state_d  = ST_IDLE;
         end
         ST_BURST: begin
            if (!wb_cyc_i) begin
               state_d = ST_IDLE;
            end else if (wb_stb_i) begin
               wb_ack_o = 1'b1;
               if (!is_burst_cti(wb_cti_i)) begin
                  state_d = ST_IDLE;
               end else begin
                  adr_d = adr_next;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         state_q <= ST_IDLE;
         adr_q   <= '0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         wcnt_q  <= wcnt_d;
      end
   end

   assign wr_en = wb_ack_o & wb_we_i;

   // Storage is deliberately outside reset so contents survive it.
   always_ff @(posedge wb_clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wb_sel_i[b]) begin
               mem_q[adr_q][8*b +: 8] <= wb_dat_i[8*b +: 8];
            end
         end
      end
   end

   assign wb_dat_o = mem_q[adr_q];

endmodule

// File: tb/tb_wb_b3_ram_responder.sv
// Randomized bench for wb_b3_ram_responder: two instances (0 and 3 wait
// states) checked against a word-array model and per-beat address arithmetic.
module tb_wb_b3_ram_responder;

   localparam int AW    = 10;
   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst [2];
   logic        cyc [2];
   logic        stb [2];
   logic        we  [2];
   logic [31:0] adr [2];
   logic [31:0] dwr [2];
   logic [3:0]  sel [2];
   logic [2:0]  cti [2];
   logic [1:0]  bte [2];
   logic [31:0] drd [2];
   logic        ack [2];

   int checks   = 0;
   int failures = 0;

   logic [31:0] mdl [2][DEPTH];

   always #5 clk = ~clk;

   wb_b3_ram_responder #(.ADR_WIDTH(AW), .WAIT_STATES(0)) u_dut0 (
      .wb_clk(clk), .wb_rst(rst[0]), .wb_adr_i(adr[0]), .wb_dat_i(dwr[0]),
      .wb_sel_i(sel[0]), .wb_cti_i(cti[0]), .wb_bte_i(bte[0]), .wb_we_i(we[0]),
      .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_dat_o(drd[0]), .wb_ack_o(ack[0])
   );

   wb_b3_ram_responder #(.ADR_WIDTH(AW), .WAIT_STATES(3)) u_dut1 (
      .wb_clk(clk), .wb_rst(rst[1]), .wb_adr_i(adr[1]), .wb_dat_i(dwr[1]),
      .wb_sel_i(sel[1]), .wb_cti_i(cti[1]), .wb_bte_i(bte[1]), .wb_we_i(we[1]),
      .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_dat_o(drd[1]), .wb_ack_o(ack[1])
   );

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   // Word touched by beat i of a burst starting at word w0.
   function automatic int exp_word(input int w0, input logic [2:0] mode,
                                   input logic [1:0] bt, input int i);
      int n;
      int base;
      if (mode == 3'b001) return w0;
      if (bt == 2'b00) return (w0 + i) % DEPTH;
      n    = (bt == 2'b01) ? 4 : (bt == 2'b10) ? 8 : 16;
      base = w0 - (w0 % n);
      return base + ((w0 % n) + i) % n;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   // Random alias bits above the word index and random byte offset.
   function automatic logic [31:0] mkadr(input int w);
      logic [31:0] hi;
      logic [31:0] wv;
      hi = $urandom;
      wv = 32'(w);
      return {hi[31:AW+2], wv[AW-1:0], hi[1:0]};
   endfunction

   task automatic classic(input int d, input bit w, input int word, input logic [31:0] wd,
                          input logic [3:0] s, input string nm, output logic [31:0] rd);
      int          ws;
      bit          got;
      logic [31:0] a;
      ws  = ws_of(d);
      got = 1'b0;
      a   = mkadr(word);
      rd  = 32'h0;
      for (int c = 0; c <= ws + 3 && !got; c++) begin
         @(negedge clk);
         cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; dwr[d] = wd;
         sel[d] = s; cti[d] = 3'b000; bte[d] = 2'($urandom);
         #1;
         checks++;
         if (ack[d] !== (c == ws + 1)) begin
            failures++;
            $display("FAIL %s ack dut%0d cycle %0d: got %b want %b", nm, d, c, ack[d], (c == ws + 1));
         end
         if (ack[d] === 1'b1) begin
            got = 1'b1;
            rd  = drd[d];
            if (w) begin
               mdl[d][word] = merge(mdl[d][word], wd, s);
            end else begin
               checks++;
               if (drd[d] !== mdl[d][word]) begin
                  failures++;
                  $display("FAIL %s data dut%0d word %0d: got %h want %h", nm, d, word, drd[d], mdl[d][word]);
               end
            end
         end
      end
      @(negedge clk);
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      #1;
      checks++;
      if (ack[d] !== 1'b0) begin
         failures++;
         $display("FAIL %s extra ack dut%0d: got %b want 0", nm, d, ack[d]);
      end
   endtask

   // we_mode: 0 read, 1 write, 2 random per beat. Beat index gap_after is
   // preceded by gap_len cycles of stb low.
   task automatic burst(input int d, input int we_mode, input int w0, input logic [2:0] mode,
                        input logic [1:0] bt, input int nb, input int gap_after,
                        input int gap_len, input bit full_sel, input string nm);
      int          ws, beat, gcnt, c, wd;
      bit          cw, gap, exp_ack;
      logic [31:0] data;
      logic [3:0]  s;
      ws = ws_of(d); beat = 0; gcnt = 0; c = 0;
      cw   = (we_mode == 2) ? bit'($urandom_range(0, 1)) : (we_mode == 1);
      data = $urandom;
      s    = full_sel ? 4'hF : 4'($urandom);
      while (beat < nb && c < ws + nb + gap_len + 4) begin
         gap = (beat == gap_after) && (gcnt < gap_len);
         wd  = exp_word(w0, mode, bt, beat);
         @(negedge clk);
         cyc[d] = 1'b1; stb[d] = !gap; we[d] = cw; adr[d] = mkadr(wd); dwr[d] = data;
         sel[d] = s; cti[d] = (beat == nb - 1) ? 3'b111 : mode; bte[d] = bt;
         #1;
         exp_ack = !gap && (beat > 0 || c == ws + 1);
         checks++;
         if (ack[d] !== exp_ack) begin
            failures++;
            $display("FAIL %s ack dut%0d beat %0d cycle %0d: got %b want %b", nm, d, beat, c, ack[d], exp_ack);
         end
         if (gap) gcnt++;
         if (ack[d] === 1'b1) begin
            if (cw) begin
               mdl[d][wd] = merge(mdl[d][wd], data, s);
            end else begin
               checks++;
               if (drd[d] !== mdl[d][wd]) begin
                  failures++;
                  $display("FAIL %s data dut%0d beat %0d word %0d: got %h want %h", nm, d, beat, wd, drd[d], mdl[d][wd]);
               end
            end
            beat++;
            cw   = (we_mode == 2) ? bit'($urandom_range(0, 1)) : (we_mode == 1);
            data = $urandom;
            s    = full_sel ? 4'hF : 4'($urandom);
         end
         c++;
      end
      if (beat < nb) begin
         checks++;
         failures++;
         $display("FAIL %s timeout dut%0d: got %0d beats want %0d", nm, d, beat, nb);
      end
      // A fresh request right after the last beat must not be acked yet.
      @(negedge clk);
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b0; cti[d] = 3'b000;
      #1;
      checks++;
      if (ack[d] !== 1'b0) begin
         failures++;
         $display("FAIL %s ack after last beat dut%0d: got %b want 0", nm, d, ack[d]);
      end
      @(negedge clk);
      cyc[d] = 1'b0; stb[d] = 1'b0;
      #1;
      checks++;
      if (ack[d] !== 1'b0) begin
         failures++;
         $display("FAIL %s ack with cyc low dut%0d: got %b want 0", nm, d, ack[d]);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         cyc[d] = 1'b1; stb[d] = 1'b1;
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (ack[d] !== 1'b0) begin
            failures++;
            $display("FAIL reset ack dut%0d: got %b want 0", d, ack[d]);
         end
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         cyc[d] = 1'b0; stb[d] = 1'b0;
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) rst[d] = 1'b0;
   endtask

   task automatic test_fill();
      for (int d = 0; d < 2; d++)
         for (int k = 0; k < DEPTH / 16; k++)
            burst(d, 1, k * 16, 3'b010, 2'b00, 16, -1, 0, 1'b1, "fill");
   endtask

   task automatic test_classic();
      logic [31:0] rd;
      classic(0, 1'b1, 4, 32'hDEADBEEF, 4'hF, "cl_wr", rd);
      classic(0, 1'b0, 4, 32'h0, 4'hF, "cl_rd", rd);
      checks++;
      if (rd !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL cl_rd value: got %h want deadbeef", rd);
      end
      classic(0, 1'b1, 8, 32'hFFFFFFFF, 4'hF, "sel_pre", rd);
      classic(0, 1'b1, 8, 32'h11223344, 4'b0101, "sel_wr", rd);
      classic(0, 1'b0, 8, 32'h0, 4'hF, "sel_rd", rd);
      checks++;
      if (rd !== 32'hFF22FF44) begin
         failures++;
         $display("FAIL sel_rd value: got %h want ff22ff44", rd);
      end
      for (int i = 0; i < 6; i++)
         classic(1, bit'(i % 2 == 0), $urandom_range(0, DEPTH - 1), $urandom, 4'($urandom), "cl_ws3", rd);
   endtask

   task automatic test_wrap4();
      burst(0, 0, 14, 3'b010, 2'b01, 4, -1, 0, 1'b0, "wrap4");
      burst(1, 0, 14, 3'b010, 2'b01, 4, -1, 0, 1'b0, "wrap4_ws3");
   endtask

   task automatic test_linear_rollover();
      logic [31:0] rd;
      burst(0, 1, DEPTH - 1, 3'b010, 2'b00, 2, -1, 0, 1'b1, "lin_roll");
      classic(0, 1'b0, DEPTH - 1, 32'h0, 4'hF, "roll_rd_top", rd);
      classic(0, 1'b0, 0, 32'h0, 4'hF, "roll_rd_zero", rd);
   endtask

   task automatic test_master_wait();
      for (int d = 0; d < 2; d++)
         burst(d, 0, $urandom_range(0, DEPTH - 8), 3'b010, 2'b00, 4, 2, 2, 1'b0, "stb_gap");
   endtask

   task automatic test_random_bursts();
      int          d, nb;
      logic [2:0]  mode;
      for (int i = 0; i < 24; i++) begin
         d    = i % 2;
         mode = ($urandom_range(0, 3) == 0) ? 3'b001 : 3'b010;
         nb   = $urandom_range(1, 8);
         burst(d, 2, $urandom_range(0, DEPTH - 1), mode, 2'($urandom), nb,
               $urandom_range(1, nb), $urandom_range(0, 2), 1'b0, "rand");
      end
   endtask

   task automatic test_reset_mid_burst();
      int          w0;
      logic [31:0] d0, d1, rd;
      bit          exp_ack;
      w0 = $urandom_range(0, DEPTH - 4);
      d0 = $urandom;
      d1 = $urandom;
      for (int c = 0; c <= 4; c++) begin
         @(negedge clk);
         cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = mkadr(w0); dwr[1] = d0;
         sel[1] = 4'hF; cti[1] = 3'b010; bte[1] = 2'b00;
         #1;
         exp_ack = (c == 4);
         checks++;
         if (ack[1] !== exp_ack) begin
            failures++;
            $display("FAIL rst_burst beat1 ack cycle %0d: got %b want %b", c, ack[1], exp_ack);
         end
      end
      mdl[1][w0] = d0;
      @(negedge clk);
      adr[1] = mkadr(w0 + 1); dwr[1] = d1; rst[1] = 1'b1;
      #1;
      checks++;
      if (ack[1] !== 1'b0) begin
         failures++;
         $display("FAIL rst_burst ack in reset: got %b want 0", ack[1]);
      end
      checks++;
      if (drd[1] !== mdl[1][0]) begin
         failures++;
         $display("FAIL rst_burst dat_o in reset: got %h want %h", drd[1], mdl[1][0]);
      end
      @(negedge clk);
      cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
      @(negedge clk);
      rst[1] = 1'b0;
      for (int k = 0; k < 4; k++)
         classic(1, 1'b0, w0 + k, 32'h0, 4'hF, "post_rst_rd", rd);
   endtask

   task automatic test_retain();
      logic [31:0] rd;
      for (int d = 0; d < 2; d++) begin
         @(negedge clk);
         cyc[d] = 1'b0; stb[d] = 1'b0; rst[d] = 1'b1;
         #1;
         checks++;
         if (drd[d] !== mdl[d][0]) begin
            failures++;
            $display("FAIL retain dat_o dut%0d: got %h want %h", d, drd[d], mdl[d][0]);
         end
         @(negedge clk);
         rst[d] = 1'b0;
         for (int i = 0; i < 3; i++)
            classic(d, 1'b0, $urandom_range(0, DEPTH - 1), 32'h0, 4'hF, "retain_rd", rd);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
         adr[d] = '0; dwr[d] = '0; sel[d] = '0; cti[d] = '0; bte[d] = '0;
      end
      test_reset();
      test_fill();
      test_classic();
      test_wrap4();
      test_linear_rollover();
      test_master_wait();
      test_random_bursts();
      test_reset_mid_burst();
      test_retain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
